// File: rtl/mem_fill_scheduler_pkg.sv
// Shared types and constants for the cache-fill scheduler.
// Block geometry lives here so the scheduler and its counters agree on it.
package mem_sched_pkg;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);

  // Clears the word offset and the byte-select bit of a byte address.
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [OFFSET_W-1:0] off);
    word_addr = base | (ADDR_W'(off) << 1);
  endfunction
endpackage

// File: rtl/mem_fill_scheduler_if.sv
// Cache/memory-side bundle of the fill scheduler; master = scheduler, slave = caches + memory.
// Requests are levels held until their tag_we / wr_ack; mem_rd/mem_wr are one-cycle pulses the memory always accepts.
interface mem_fill_scheduler_if;
  import mem_sched_pkg::*;

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_valid;
  logic [DATA_W-1:0] fill_data;
  logic [ADDR_W-1:0] fill_addr;
  logic              ic_fill_we;
  logic              dc_fill_we;
  logic              ic_tag_we;
  logic              dc_tag_we;
  logic              ic_busy;
  logic              dc_busy;
  logic              stall_n;
  state_t            dbg_state;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_addr, wr_req, wr_addr, wr_data,
           mem_rdata, mem_data_valid,
    output wr_ack, mem_addr, mem_wdata, mem_wr, mem_rd, fill_data, fill_addr,
           ic_fill_we, dc_fill_we, ic_tag_we, dc_tag_we, ic_busy, dc_busy,
           stall_n, dbg_state
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_addr, wr_req, wr_addr, wr_data,
           mem_rdata, mem_data_valid,
    input  wr_ack, mem_addr, mem_wdata, mem_wr, mem_rd, fill_data, fill_addr,
           ic_fill_we, dc_fill_we, ic_tag_we, dc_tag_we, ic_busy, dc_busy,
           stall_n, dbg_state
  );
endinterface

// File: rtl/mem_fill_scheduler_counter.sv
// Word-offset counter for one block: val wraps modulo WORDS_PER_BLOCK, cnt counts words
// since the last load so 'last' marks the final word whatever offset the block started at.
module mem_fill_counter
  import mem_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [OFFSET_W-1:0] load_val,
  input  logic                en,
  output logic [OFFSET_W-1:0] val,
  output logic                last
);
  logic [OFFSET_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
      cnt <= '0;
    end else if (load) begin
      val <= load_val;
      cnt <= '0;
    end else if (en) begin
      val <= val + OFFSET_W'(1);
      cnt <= cnt + OFFSET_W'(1);
    end
  end

  assign last = (cnt == OFFSET_W'(WORDS_PER_BLOCK - 1));
endmodule

// File: rtl/mem_fill_scheduler.sv
// Arbitrates icache fills, dcache fills and write-through stores onto a pipelined memory.
// Optional CRITICAL_WORD_FIRST_EN: fills start at the missing word and wrap inside the block.
module mem_fill_scheduler
  import mem_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  mem_fill_scheduler_if.master bus
);
  state_t              state;
  owner_t              owner;
  owner_t              rr_last;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic                wr_ack_q;
  logic                ic_busy_q;
  logic                dc_busy_q;

  logic                grant_ic;
  logic                grant_dc;
  logic                grant;
  logic [ADDR_W-1:0]   grant_addr;
  logic [ADDR_W-1:0]   grant_base;
  logic [OFFSET_W-1:0] start_off;
  logic [OFFSET_W-1:0] iss_off;
  logic [OFFSET_W-1:0] rcv_off;
  logic                iss_last;
  logic                rcv_last;
  logic                iss_en;
  logic                rcv_fire;
  logic                rcv_done;

  // Stores win outright; contended fills alternate away from the previous winner.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state == IDLE && !bus.wr_req) begin
      if (bus.ic_req && bus.dc_req) begin
        grant_dc = (rr_last == OWN_IC);
        grant_ic = (rr_last == OWN_DC);
      end else begin
        grant_ic = bus.ic_req;
        grant_dc = bus.dc_req;
      end
    end
  end

  assign grant      = grant_ic | grant_dc;
  assign grant_addr = grant_dc ? bus.dc_addr : bus.ic_addr;
  assign grant_base = grant_addr & BLOCK_MASK;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_off = grant_addr[OFFSET_W:1];
`else
  assign start_off = '0;
`endif

  assign iss_en   = (state == FILL) && mem_rd_q && !iss_last;
  assign rcv_fire = (state == FILL) && bus.mem_data_valid;
  assign rcv_done = rcv_fire && rcv_last;

  mem_fill_counter u_iss (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant),
    .load_val (start_off),
    .en       (iss_en),
    .val      (iss_off),
    .last     (iss_last)
  );

  mem_fill_counter u_rcv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant),
    .load_val (start_off),
    .en       (rcv_fire),
    .val      (rcv_off),
    .last     (rcv_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_IC;
      rr_last     <= OWN_IC;
      base        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      ic_busy_q   <= 1'b0;
      dc_busy_q   <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      wr_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_req) begin
            state       <= WRITE;
            mem_wr_q    <= 1'b1;
            wr_ack_q    <= 1'b1;
            mem_addr_q  <= bus.wr_addr;
            mem_wdata_q <= bus.wr_data;
          end else if (grant) begin
            state      <= FILL;
            owner      <= grant_dc ? OWN_DC : OWN_IC;
            rr_last    <= grant_dc ? OWN_DC : OWN_IC;
            base       <= grant_base;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= word_addr(grant_base, start_off);
            ic_busy_q  <= grant_ic;
            dc_busy_q  <= grant_dc;
          end
        end
        WRITE: state <= IDLE;
        FILL: begin
          // mem_addr keeps the last issued word once the block is fully requested.
          if (mem_rd_q) begin
            if (iss_last) mem_rd_q <= 1'b0;
            else          mem_addr_q <= word_addr(base, iss_off + OFFSET_W'(1));
          end
          if (rcv_done) begin
            state     <= IDLE;
            ic_busy_q <= 1'b0;
            dc_busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ack     = wr_ack_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.fill_data  = bus.mem_rdata;
  assign bus.fill_addr  = word_addr(base, rcv_off);
  assign bus.ic_fill_we = rcv_fire && (owner == OWN_IC);
  assign bus.dc_fill_we = rcv_fire && (owner == OWN_DC);
  assign bus.ic_tag_we  = rcv_done && (owner == OWN_IC);
  assign bus.dc_tag_we  = rcv_done && (owner == OWN_DC);
  assign bus.ic_busy    = ic_busy_q;
  assign bus.dc_busy    = dc_busy_q;
  assign bus.stall_n    = ~(ic_busy_q | dc_busy_q);
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_mem_fill_scheduler.sv
// Bench for mem_fill_scheduler: fixed-latency memory model, vector table, corner sequences
// and random rounds scored against a block-level model of the grant/fill rules.
module tb_mem_fill_scheduler;
  import mem_sched_pkg::*;

  localparam int MEM_LATENCY = 4;
  localparam int W = 40;
  localparam int N = WORDS_PER_BLOCK;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef logic [W-1:0] q_t[$];
  typedef struct {
    bit          ic;
    bit          dc;
    bit          wr;
    logic [15:0] ica;
    logic [15:0] dca;
    logic [15:0] wra;
    logic [15:0] wrd;
    logic [15:0] exp_first;
    int          exp_nrd;
    int          exp_stall;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_fill_scheduler_if bus();
  mem_fill_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // clock/reset and memory model
  logic        pipe_v [MEM_LATENCY];
  logic [15:0] pipe_a [MEM_LATENCY];
  logic        stray_v = 1'b0;
  logic [15:0] stray_d = 16'h0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= 16'h0;
      end
    end else begin
      pipe_v[0] <= bus.mem_rd;
      pipe_a[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  assign bus.mem_data_valid = pipe_v[MEM_LATENCY-1] | stray_v;
  assign bus.mem_rdata      = pipe_v[MEM_LATENCY-1] ? mem_fn(pipe_a[MEM_LATENCY-1]) : stray_d;

  // scoreboard state
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  q_t     obs_rd, obs_fill, obs_wr, obs_tag;
  q_t     exp_rd, exp_fill, exp_wr, exp_tag;
  int     stall_cyc, ic_busy_cyc, dc_busy_cyc;
  int     exp_stall, exp_ic_busy, exp_dc_busy;
  int     tag_cyc, wr_cyc;
  logic   wr_stall_n, wr_ack_seen;
  bit     auto_drop_dc = 1'b1;
  owner_t m_rr = OWN_IC;
  vec_t   vecs[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cmp_q(input string name, input q_t e, input q_t o);
    check({name, ".len"}, W'(o.size()), W'(e.size()));
    for (int i = 0; i < e.size() && i < o.size(); i++)
      check($sformatf("%s[%0d]", name, i), o[i], e[i]);
  endtask

  task automatic clear_obs();
    obs_rd.delete(); obs_fill.delete(); obs_wr.delete(); obs_tag.delete();
    exp_rd.delete(); exp_fill.delete(); exp_wr.delete(); exp_tag.delete();
    stall_cyc = 0; ic_busy_cyc = 0; dc_busy_cyc = 0;
    exp_stall = 0; exp_ic_busy = 0; exp_dc_busy = 0;
    tag_cyc = -1; wr_cyc = -1; wr_stall_n = 1'b0; wr_ack_seen = 1'b0;
  endtask

  // driver: one cycle, sampled on the falling edge, requests dropped on their completion
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.mem_rd) obs_rd.push_back(W'(bus.mem_addr));
    if (bus.mem_wr) begin
      obs_wr.push_back(W'({bus.mem_addr, bus.mem_wdata}));
      wr_cyc      = cyc;
      wr_stall_n  = bus.stall_n;
      wr_ack_seen = bus.wr_ack;
    end
    if (bus.ic_fill_we) obs_fill.push_back(W'({1'b0, bus.fill_addr, bus.fill_data}));
    if (bus.dc_fill_we) obs_fill.push_back(W'({1'b1, bus.fill_addr, bus.fill_data}));
    if (bus.ic_tag_we) begin obs_tag.push_back(W'(OWN_IC)); tag_cyc = cyc; end
    if (bus.dc_tag_we) begin obs_tag.push_back(W'(OWN_DC)); tag_cyc = cyc; end
    if (!bus.stall_n) stall_cyc++;
    if (bus.ic_busy) ic_busy_cyc++;
    if (bus.dc_busy) dc_busy_cyc++;
    if (bus.ic_tag_we) bus.ic_req = 1'b0;
    if (bus.dc_tag_we && auto_drop_dc) bus.dc_req = 1'b0;
    if (bus.wr_ack) bus.wr_req = 1'b0;
  endtask

  // reference model: whole-block view of one fill
  task automatic model_fill(input owner_t o, input logic [15:0] a);
    logic [15:0] blk, wa;
    int start;
    blk   = 16'(a - (a % (2 * N)));
    start = CWF ? int'((a / 2) % N) : 0;
    for (int i = 0; i < N; i++) begin
      wa = 16'(blk + 2 * ((start + i) % N));
      exp_rd.push_back(W'(wa));
      exp_fill.push_back(W'({o == OWN_DC, wa, mem_fn(wa)}));
    end
    exp_tag.push_back(W'(o));
    exp_stall += N + MEM_LATENCY;
    if (o == OWN_IC) exp_ic_busy += N + MEM_LATENCY;
    else             exp_dc_busy += N + MEM_LATENCY;
    m_rr = o;
  endtask

  task automatic model_round(input bit ic, input bit dc, input bit wr,
                             input logic [15:0] ica, input logic [15:0] dca,
                             input logic [15:0] wra, input logic [15:0] wrd);
    if (wr) exp_wr.push_back(W'({wra, wrd}));
    if (ic && dc) begin
      if (m_rr == OWN_IC) begin model_fill(OWN_DC, dca); model_fill(OWN_IC, ica); end
      else                begin model_fill(OWN_IC, ica); model_fill(OWN_DC, dca); end
    end else if (ic) model_fill(OWN_IC, ica);
    else if (dc)     model_fill(OWN_DC, dca);
  endtask

  task automatic run_round(input bit ic, input bit dc, input bit wr,
                           input logic [15:0] ica, input logic [15:0] dca,
                           input logic [15:0] wra, input logic [15:0] wrd,
                           output logic [15:0] first_rd, output int nrd, output int stalls);
    int n;
    clear_obs();
    model_round(ic, dc, wr, ica, dca, wra, wrd);
    bus.ic_addr = ica; bus.dc_addr = dca; bus.wr_addr = wra; bus.wr_data = wrd;
    bus.ic_req = ic; bus.dc_req = dc; bus.wr_req = wr;
    n = 0;
    while ((bus.ic_req || bus.dc_req || bus.wr_req) && n < 400) begin step(); n++; end
    check("round_timeout", W'(n >= 400), W'(0));
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.wr_req = 1'b0;
    repeat (2) step();
    cmp_q("rd", exp_rd, obs_rd);
    cmp_q("fill", exp_fill, obs_fill);
    cmp_q("wr", exp_wr, obs_wr);
    cmp_q("tag", exp_tag, obs_tag);
    check("stall_cycles", W'(stall_cyc), W'(exp_stall));
    check("ic_busy_cycles", W'(ic_busy_cyc), W'(exp_ic_busy));
    check("dc_busy_cycles", W'(dc_busy_cyc), W'(exp_dc_busy));
    first_rd = (obs_rd.size() > 0) ? obs_rd[0][15:0] : 16'h0;
    nrd      = obs_rd.size();
    stalls   = stall_cyc;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".wr_ack"},     W'(bus.wr_ack),     W'(0));
    check({tag, ".mem_addr"},   W'(bus.mem_addr),   W'(0));
    check({tag, ".mem_wdata"},  W'(bus.mem_wdata),  W'(0));
    check({tag, ".mem_wr"},     W'(bus.mem_wr),     W'(0));
    check({tag, ".mem_rd"},     W'(bus.mem_rd),     W'(0));
    check({tag, ".fill_data"},  W'(bus.fill_data),  W'(0));
    check({tag, ".fill_addr"},  W'(bus.fill_addr),  W'(0));
    check({tag, ".ic_fill_we"}, W'(bus.ic_fill_we), W'(0));
    check({tag, ".dc_fill_we"}, W'(bus.dc_fill_we), W'(0));
    check({tag, ".ic_tag_we"},  W'(bus.ic_tag_we),  W'(0));
    check({tag, ".dc_tag_we"},  W'(bus.dc_tag_we),  W'(0));
    check({tag, ".ic_busy"},    W'(bus.ic_busy),    W'(0));
    check({tag, ".dc_busy"},    W'(bus.dc_busy),    W'(0));
    check({tag, ".stall_n"},    W'(bus.stall_n),    W'(1));
    check({tag, ".state"},      W'(bus.dbg_state),  W'(IDLE));
  endtask

  task automatic do_reset();
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.wr_req = 1'b0; stray_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    m_rr  = OWN_IC;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] first;
    int nrd, stalls, n, pick;
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.wr_req = 1'b0;
    bus.ic_addr = 16'h0; bus.dc_addr = 16'h0; bus.wr_addr = 16'h0; bus.wr_data = 16'h0;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h1236, 16'h2000, 16'h0000, 16'h0000, 16'h2000, 2*N, 24};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h1236, 16'h0000, 16'h0000, 16'h0000,
                CWF ? 16'h1236 : 16'h1230, N, 12};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 16'h0000, 0, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h4444, 16'h8001, 16'h1234, 16'h5678, 16'h8000, 2*N, 24};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000,
                CWF ? 16'hFFFE : 16'hFFF0, N, 12};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFA, 16'h0000, 16'h0000,
                CWF ? 16'hFFFA : 16'hFFF0, N, 12};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // vector table
    for (int v = 0; v < 6; v++) begin
      run_round(vecs[v].ic, vecs[v].dc, vecs[v].wr, vecs[v].ica, vecs[v].dca,
                vecs[v].wra, vecs[v].wrd, first, nrd, stalls);
      if (vecs[v].exp_nrd > 0)
        check($sformatf("vec%0d.first_rd", v), W'(first), W'(vecs[v].exp_first));
      check($sformatf("vec%0d.nrd", v), W'(nrd), W'(vecs[v].exp_nrd));
      check($sformatf("vec%0d.stall", v), W'(stalls), W'(vecs[v].exp_stall));
    end

    // contention from reset with dcache re-missing: order dc, ic, dc
    do_reset();
    clear_obs();
    auto_drop_dc = 1'b0;
    bus.ic_addr = 16'h1236; bus.dc_addr = 16'h2000;
    bus.ic_req = 1'b1; bus.dc_req = 1'b1;
    n = 0;
    while (obs_tag.size() < 2 && n < 200) begin step(); n++; end
    auto_drop_dc = 1'b1;
    while (bus.dc_req && n < 300) begin step(); n++; end
    check("rr_timeout", W'(n >= 300), W'(0));
    bus.ic_req = 1'b0; bus.dc_req = 1'b0;
    repeat (2) step();
    exp_tag.push_back(W'(OWN_DC)); exp_tag.push_back(W'(OWN_IC)); exp_tag.push_back(W'(OWN_DC));
    cmp_q("rr_tag", exp_tag, obs_tag);
    check("rr_first_rd", (obs_rd.size() > 0) ? obs_rd[0] : W'(0), W'(16'h2000));
    m_rr = OWN_DC;

    // store arriving mid-fill waits for the fill, then issues without stalling
    clear_obs();
    bus.ic_addr = 16'h1236; bus.ic_req = 1'b1;
    repeat (3) step();
    bus.wr_addr = 16'h0040; bus.wr_data = 16'hBEEF; bus.wr_req = 1'b1;
    n = 0;
    while ((bus.ic_req || bus.wr_req) && n < 200) begin step(); n++; end
    check("wr_hold_timeout", W'(n >= 200), W'(0));
    bus.ic_req = 1'b0; bus.wr_req = 1'b0;
    repeat (2) step();
    check("wr_after_fill", W'(wr_cyc), W'(tag_cyc + 2));
    check("wr_count", W'(obs_wr.size()), W'(1));
    check("wr_content", (obs_wr.size() > 0) ? obs_wr[0] : W'(0), W'({16'h0040, 16'hBEEF}));
    check("wr_stall_n", W'(wr_stall_n), W'(1));
    check("wr_ack_with_wr", W'(wr_ack_seen), W'(1));
    check("wr_fill_tag", (obs_tag.size() > 0) ? obs_tag[0] : W'(3), W'(OWN_IC));
    m_rr = OWN_IC;

    // reset after the third returned word aborts the fill
    clear_obs();
    bus.ic_addr = 16'h1236; bus.ic_req = 1'b1;
    n = 0;
    while (obs_fill.size() < 3 && n < 100) begin step(); n++; end
    check("abort_timeout", W'(n >= 100), W'(0));
    rst_n = 1'b0;
    bus.ic_req = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("abort_no_tag", W'(obs_tag.size()), W'(0));
    m_rr = OWN_IC;
    run_round(1'b1, 1'b0, 1'b0, 16'h1236, 16'h0, 16'h0, 16'h0, first, nrd, stalls);
    check("restart_first_rd", W'(first), W'(CWF ? 16'h1236 : 16'h1230));

    // stray data-valid while idle
    stray_d = 16'h1111; stray_v = 1'b1;
    #2;
    check("stray.ic_fill_we", W'(bus.ic_fill_we), W'(0));
    check("stray.dc_fill_we", W'(bus.dc_fill_we), W'(0));
    check("stray.state", W'(bus.dbg_state), W'(IDLE));
    step();
    check("stray.state_after", W'(bus.dbg_state), W'(IDLE));
    stray_v = 1'b0; stray_d = 16'h0;

    // random rounds
    do_reset();
    for (int r = 0; r < 30; r++) begin
      pick = $urandom_range(1, 7);
      run_round(pick[0], pick[1], pick[2],
                16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                first, nrd, stalls);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_fill_scheduler.md
Name: mem_fill_scheduler

Overview:
Sequences all main-memory traffic for the CPU's two caches.
- Arbitrates between icache block fills, dcache block fills and dcache write-through stores.
- Drives a pipelined main memory (one request per cycle, fixed read latency) and streams returned words into the selected cache's data array, then updates that cache's tag array.
- Sits between the cache pair and the memory model and generates the global pipeline stall.

Parameters:
WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of 2.
MEM_LATENCY, 4, cycles from read issue to mem_data_valid (memory-side property; used by the bench only).
ADDR_W, 16, byte address width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ic_req  in  1  icache miss; level, held until ic_tag_we
ic_addr  in  16  icache miss byte address
dc_req  in  1  dcache miss; level, held until dc_tag_we
dc_addr  in  16  dcache miss byte address
wr_req  in  1  dcache write-through request; level, held until wr_ack
wr_addr  in  16  store byte address
wr_data  in  16  store data
wr_ack  out  1  one-cycle pulse; store issued this cycle
mem_addr  out  16  memory request address
mem_wdata  out  16  memory write data
mem_wr  out  1  memory write enable
mem_rd  out  1  memory read request
mem_rdata  in  16  memory read data
mem_data_valid  in  1  mem_rdata valid
fill_data  out  16  word being written into a cache (= mem_rdata)
fill_addr  out  16  byte address of that word
ic_fill_we, dc_fill_we  out  1 each  data-array write enables
ic_tag_we, dc_tag_we  out  1 each  tag-array write pulse on the last word
ic_busy, dc_busy  out  1 each  fill in progress for that cache
stall_n  out  1  low while any fill is in progress

Behaviour:
- States are IDLE, WRITE and FILL. Register rr_last (0 = icache, 1 = dcache) records the last fill grant.
- Reset: state IDLE, counters 0, rr_last 0, and every output 0 except stall_n = 1.
- IDLE grant priority:
  - wr_req goes to WRITE.
  - Otherwise, a single fill requester is granted.
  - If both fill requesters are present, the one not equal to rr_last is granted.
  - A grant latches base = addr with the low log2(WORDS_PER_BLOCK)+1 bits cleared, sets the owner and rr_last, and enters FILL.
- WRITE lasts one cycle: mem_wr = 1, mem_addr = wr_addr, mem_wdata = wr_data, wr_ack = 1; then return to IDLE.
- FILL:
  - Issue counter: mem_rd = 1 and mem_addr = base + 2*iss for iss = 0..WORDS_PER_BLOCK-1, one per cycle starting the cycle after the grant. Once all words are issued, mem_rd = 0 and mem_addr holds the last value.
  - Receive counter: on each mem_data_valid, owner fill_we = 1, fill_addr = base + 2*rcv, and rcv increments.
  - On the last word: owner tag_we = 1 in the same cycle, then IDLE next cycle.
- owner busy is high from the cycle after the grant through the tag_we cycle inclusive; stall_n = ~(ic_busy | dc_busy).
- Pending wr_req and the other cache's miss wait during FILL and are not dropped. A write in WRITE never raises busy.
- mem_data_valid outside FILL is ignored: no fill_we.
- Address arithmetic is modulo 2^16, so a block at 0xFFF0 never wraps outside its block.
- Asynchronous reset mid-fill aborts immediately: no tag_we, counters cleared.
- fill_data = mem_rdata combinationally.

Optional Feature:
CRITICAL_WORD_FIRST_EN:
- Defined: iss and rcv start at the miss word offset ((addr>>1) mod WORDS_PER_BLOCK) and wrap modulo WORDS_PER_BLOCK. tag_we fires on the WORDS_PER_BLOCK-th received word.
- Undefined: both counters start at offset 0.

Decomposition:
- Package mem_sched_pkg holds:
  - state enum {IDLE, WRITE, FILL}
  - owner enum {OWN_IC, OWN_DC}
  - OFFSET_W = log2(WORDS_PER_BLOCK)
  - block mask constant
- One sub-module, mem_fill_counter: a modulo-WORDS_PER_BLOCK counter with load, enable and done-count. It is instantiated twice, for issue and receive.

Test Plan:
- ic_req=1, ic_addr=0x1236, no contention:
  - mem_rd issues 0x1230..0x123E on consecutive cycles.
  - With 4-cycle latency, ic_fill_we pulses 8 cycles; ic_tag_we on the 8th word.
  - stall_n low for 1+4+7 = 12 cycles.
- ic_req and dc_req both 1 from reset: dcache granted first (rr_last=0). After dc_tag_we, icache granted; dcache stays requested and is not regranted until icache completes.
- wr_req=1, wr_addr=0x0040, wr_data=0xBEEF during an active fill:
  - Held off until the fill completes.
  - Then one cycle with mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, wr_ack=1.
  - stall_n stays 1 during the write.
- rst_n pulsed low after the 3rd returned word: all outputs return to reset values, no tag_we. A re-asserted request restarts at word 0.
- Stray mem_data_valid while IDLE: no fill_we, state unchanged.
- CRITICAL_WORD_FIRST_EN defined, dc_addr=0xFFFA: issue order 0xFFFA, 0xFFFC, 0xFFFE, 0xFFF0..0xFFF8; dc_tag_we after 8 words.
